// File: rtl/shift8_rx_pkg.sv
// Shared shifter definitions: FSM state encoding and direction constants,
// common to this receiver and the matching transmitter.
package shift8_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    STOP = 2'b10
  } rx_state_e;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift8_rx_shift_reg_sipo.sv
// Serial-in parallel-out shift register; clr has priority over shift.
// dir selects LSB-first (enter at MSB, shift right) or MSB-first (enter at LSB, shift left).
module shift_reg_sipo
  import shift8_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             dir,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (shift) begin
      if (dir == DIR_MSB_FIRST) r_q <= {r_q[WIDTH-2:0], sin};
      else                      r_q <= {sin, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/shift8_rx.sv
// Framed serial receiver: start bit (0), WIDTH data bits, stop bit (1), sampled on en strobes.
// valid/frame_err are registered one-cycle pulses in the cycle after the stop-bit edge.
module shift8_rx
  import shift8_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sin,
  input  logic             dir,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  rx_state_e        r_state;
  rx_state_e        w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_ferr;
  logic [WIDTH-1:0] w_q;
  logic             w_start;
  logic             w_shift;
  logic             w_load;
  logic             w_err;

  shift_reg_sipo #(.WIDTH(WIDTH)) u_sipo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_start),
    .shift   (w_shift),
    .dir     (r_dir),
    .sin     (sin),
    .q       (w_q)
  );

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && !sin) begin
          w_next  = DATA;
          w_start = 1'b1;
        end
      end
      DATA: begin
        if (en) begin
          w_shift = 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) w_next = STOP;
        end
      end
      STOP: begin
        if (en) begin
          w_load = sin;
          w_err  = !sin;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_LSB_FIRST;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_load;
      r_ferr  <= w_err;
      // Direction is latched at the start bit so mid-frame changes are ignored.
      if (w_start) begin
        r_cnt <= '0;
        r_dir <= dir;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load) r_dout <= w_q;
    end
  end

  assign dout      = r_dout;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/shift8_rx.md
SHIFT8_RX -- requirements
Module: shift8_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word length in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: bit strobe; sin is sampled only on edges where en=1.
REQ-005 The block SHALL have port sin, input, 1 bit: serial data line from the shifter; idles high.
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = LSB-first (shift right), 1 = MSB-first (shift left).
REQ-007 The block SHALL have port dout, output, WIDTH bits: last correctly framed word.
REQ-008 The block SHALL have port valid, output, 1 bit: one-cycle pulse when dout updates.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.

Function
REQ-011 The block SHALL implement the FSM states IDLE, DATA and STOP.
REQ-012 In IDLE, en=1 with sin=0 (start bit) SHALL move the FSM to DATA, clear the bit counter and clear the shift register; en=1 with sin=1 SHALL keep the FSM in IDLE.
REQ-013 In DATA, each en=1 SHALL shift sin into the shift register and increment the bit counter.
- dir=0: sin enters bit WIDTH-1 and the register shifts right.
- dir=1: sin enters bit 0 and the register shifts left.
REQ-014 After the WIDTH-th data strobe, the FSM SHALL move to STOP.
REQ-015 In STOP, en=1 with sin=1 SHALL load dout from the shift register, pulse valid for exactly that one cycle and return to IDLE.
REQ-016 In STOP, en=1 with sin=0 SHALL pulse frame_err for one cycle, leave dout unchanged and return to IDLE.
REQ-017 With en=0, the FSM, counter and shift register SHALL hold, and valid and frame_err SHALL be 0.
REQ-018 dir SHALL be sampled once, at the start bit, and held for the whole frame; changes to dir mid-frame SHALL have no effect.
REQ-019 busy SHALL be 1 in DATA and STOP and 0 in IDLE.
REQ-020 Latency SHALL be as follows: valid asserts in the clock cycle after the edge that samples the stop bit; a frame needs WIDTH+2 strobes in total.
REQ-021 After valid, the next start bit SHALL be accepted on the very next en strobe, with no dead cycle.
REQ-022 valid and frame_err SHALL never be high in the same cycle.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within a frame.

Reset
REQ-024 Assertion of reset_n=0 SHALL immediately (asynchronously) force the FSM to IDLE, the counter to 0, the shift register to 0, dout to 0, and valid, busy and frame_err to 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial word, with no valid or frame_err pulse.
REQ-026 The first edge after reset_n rises SHALL be a normal IDLE cycle.

Structure
REQ-027 The FSM state encoding (IDLE=2'b00, DATA=2'b01, STOP=2'b10) and the direction constants SHALL live in the shared shifter package, for reuse by the matching transmitter.
REQ-028 The shift register SHALL be a sub-module, shift_reg_sipo, with ports clk, reset_n, clr, shift, dir, sin and q; the FSM and counter SHALL be in shift8_rx.

Verification
REQ-029 Scenario: reset, then en=1 every cycle with dir=0 and sin = 0, 1,0,1,0,0,1,0,1, 1 -> dout=8'hA5, valid high for 1 cycle, frame_err=0.
REQ-030 Scenario: same bit stream with dir=1 -> dout=8'hA5 bit-reversed (8'hA5 is a palindrome, so repeat with 8'h3C data -> dout=8'h3C in MSB-first order).
REQ-031 Scenario: stop bit = 0 after 8'hFF data -> frame_err pulse, valid=0, dout keeps its previous value.
REQ-032 Scenario: en toggling 1-0-0-1 throughout a frame carrying 8'h5A -> identical result to continuous en; busy stays high across the gaps.
REQ-033 Scenario: reset_n pulsed low after the 4th data bit, then a full frame of 8'h81 -> no pulse from the aborted frame; dout=8'h81 with valid.
REQ-034 Scenario: two back-to-back frames 8'h12 then 8'h34 with no idle bit between them -> two valid pulses, with dout=8'h12 and then 8'h34.
